sha3_sequencer: RTL and testbench
=================================

Name: sha3_sequencer

Overview:
- Top-level control FSM for the SHA3-512 core: orders state clear, block absorb, padding, the 24-round Keccak-f permutation and digest squeeze.
- Drives the byte-absorb block through its go/kill/done/count interface.
- Drives the datapath state register through clear, pad and round-enable strobes, and feeds the digest out through a valid/ready byte stream.
- Does not handle data; control and counters only.

Parameters:
RATE_BYTES, 72, bytes per absorbed block (SHA3-512 rate)
NUM_ROUNDS, 24, permutation rounds per block
DIGEST_BYTES, 64, output digest length in bytes
TIMEOUT_CYCLES, 1024, absorb watchdog limit (used only with the optional feature)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset; 0 at a rising edge resets the block
start  in  1  begin a new hash; sampled only in IDLE
abort_req  in  1  abort the current hash; level-sensitive
data_done  in  1  message source has no further bytes
fifo_empty  in  1  input byte FIFO empty
absorb_go  out  1  one-cycle start pulse to the absorb block
absorb_kill  out  1  abort to the absorb block
absorb_done  in  1  absorb block finished one block (1-cycle pulse)
absorb_count  in  7  bytes captured in that block, valid with absorb_done
state_clr  out  1  zero the 1600-bit state register
pad_strobe  out  1  XOR pad into state: 0x06 at byte pad_pos, 0x80 at byte RATE_BYTES-1
pad_pos  out  7  padding start byte, valid with pad_strobe
perm_en  out  1  state register takes round(state, round_idx) this cycle
round_idx  out  5  current round index 0..NUM_ROUNDS-1
dig_valid  out  1  digest byte available
dig_ready  in  1  consumer accepts digest byte
dig_byte_sel  out  6  digest byte index 0..DIGEST_BYTES-1
dig_last  out  1  dig_valid on final byte
busy  out  1  high in any state except IDLE
hash_done  out  1  one-cycle pulse after the last digest byte handshake
error  out  1  sticky fault flag; cleared when start is accepted

Behaviour:
- Reset (reset=0 at an edge): state goes to IDLE. All outputs are 0, all counters are 0, and the need_pad and final flags are cleared. This also applies in the middle of an operation.
- States: IDLE, CLEAR, ABS_GO, ABS_WAIT, PAD, PERM, SQUEEZE, DONE, ABORT, ERROR.
- IDLE: if start=1, clear error and go to CLEAR. Latency: start at cycle 0; state_clr at cycle 1; absorb_go at cycle 2.
- CLEAR: state_clr=1 for one cycle, then go to ABS_GO.
- ABS_GO: absorb_go=1 for one cycle, then go to ABS_WAIT.
- ABS_WAIT, on absorb_done with absorb_count=N:
  - N>RATE_BYTES: go to ERROR.
  - N<RATE_BYTES: pad_pos<=N, go to PAD.
  - N==RATE_BYTES and data_done&&fifo_empty: set need_pad (pad_pos=0), go to PERM.
  - N==RATE_BYTES otherwise: go to PERM.
- PAD: pad_strobe=1 for one cycle, clear need_pad, set final, go to PERM.
- PERM:
  - perm_en=1 for exactly NUM_ROUNDS consecutive cycles; round_idx runs 0..23.
  - round_idx is 5 bits; it is cleared on PERM entry and never wraps inside PERM.
  - After round_idx=23, exit to: SQUEEZE if final; else PAD if need_pad; else ABS_GO.
- SQUEEZE:
  - dig_valid=1 throughout.
  - dig_byte_sel increments on dig_valid&&dig_ready and holds otherwise.
  - dig_last=1 when dig_byte_sel=63.
  - A handshake on the last byte goes to DONE.
- DONE: hash_done=1 for one cycle, clear final, go to IDLE.
- abort_req=1 in any non-IDLE state has priority over every other transition:
  - Go to ABORT.
  - absorb_kill=1 while in ABORT.
  - perm_en, pad_strobe, dig_valid and absorb_go are forced to 0 from the next cycle.
  - When abort_req=0, go to IDLE.
  - abort_req in IDLE is ignored.
- ERROR: absorb_kill=1 for one cycle, error=1, then go to IDLE. error stays set until the next accepted start.
- start outside IDLE is ignored. start and abort_req together in IDLE: start wins.
- Arithmetic: absorb_count is compared unsigned. dig_byte_sel is 6 bits and cannot exceed 63.

Optional Feature:
SHA3_SEQ_TIMEOUT_EN
- Defined:
  - An 11-bit watchdog counter clears on ABS_WAIT entry and increments every cycle in ABS_WAIT.
  - Reaching TIMEOUT_CYCLES without absorb_done goes to ERROR (absorb_kill pulse, error=1).
  - absorb_done arriving on the expiry cycle wins.
- Undefined: no counter; ABS_WAIT waits indefinitely; error is raised only by absorb_count overflow.

Test Plan:
- Empty message: start; absorb_done with count=0, data_done=1, fifo_empty=1 -> pad_pos=0 pulse, 24 perm_en cycles (round_idx 0..23), 64 digest bytes with dig_ready=1, hash_done pulse, busy=0.
- 72-byte message: count=72 with data_done&&fifo_empty -> PERM(24), PAD pos 0, PERM(24); 48 total perm_en cycles and a single absorb_go.
- 100-byte message: count=72 (data_done=0) -> PERM -> second absorb_go -> count=28 -> pad_pos=28 -> PERM -> SQUEEZE.
- Digest backpressure: dig_ready toggling 1,0,0,1 -> dig_byte_sel advances only on ready cycles; dig_last only at 63; hash_done only after 64 handshakes.
- Abort at round_idx=10, held 3 cycles -> perm_en=0 next cycle, absorb_kill=1 for 3 cycles, IDLE after release; a later start runs the hash normally.
- count=80 -> ERROR, absorb_kill pulse, error=1 until next start; with SHA3_SEQ_TIMEOUT_EN and no absorb_done for 1024 cycles -> same response.

Source files
------------

// File: rtl/sha3_sequencer.sv
// sha3_sequencer: control FSM for SHA3-512; orders clear, absorb, pad, permute and digest squeeze.
// Latency: start -> state_clr next cycle -> absorb_go the cycle after; each permutation is NUM_ROUNDS cycles.
// Backpressure: ABS_WAIT stalls until absorb_done; SQUEEZE holds dig_byte_sel while dig_ready is low.
//
// Optional build macro SHA3_SEQ_TIMEOUT_EN adds an absorb watchdog: TIMEOUT_CYCLES in ABS_WAIT
// without absorb_done raises error. Without it ABS_WAIT waits indefinitely.
//
// Ports:
//   clk, reset (synchronous, active-low)
//   start, abort_req                    : hash control (start sampled in IDLE only; abort level-sensitive)
//   data_done, fifo_empty               : message source status, used to detect an exactly-full last block
//   absorb_go/kill/done/count           : byte-absorb block handshake
//   state_clr, pad_strobe, pad_pos      : state register clear and padding strobes
//   perm_en, round_idx                  : one Keccak round per cycle while perm_en is high
//   dig_valid/ready/byte_sel/last       : digest byte stream
//   busy, hash_done, error              : status (error is sticky until the next accepted start)
// All outputs are registered.
module sha3_sequencer #(
    parameter int RATE_BYTES     = 72,
    parameter int NUM_ROUNDS     = 24,
    parameter int DIGEST_BYTES   = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort_req,
    input  logic       data_done,
    input  logic       fifo_empty,
    output logic       absorb_go,
    output logic       absorb_kill,
    input  logic       absorb_done,
    input  logic [6:0] absorb_count,
    output logic       state_clr,
    output logic       pad_strobe,
    output logic [6:0] pad_pos,
    output logic       perm_en,
    output logic [4:0] round_idx,
    output logic       dig_valid,
    input  logic       dig_ready,
    output logic [5:0] dig_byte_sel,
    output logic       dig_last,
    output logic       busy,
    output logic       hash_done,
    output logic       error
);

    typedef enum logic [3:0] {
        IDLE,
        CLEAR,
        ABS_GO,
        ABS_WAIT,
        PAD,
        PERM,
        SQUEEZE,
        DONE,
        ABORT,
        ERROR
    } state_t;

    localparam logic [6:0] RATE_L     = 7'(RATE_BYTES);
    localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS - 1);
    localparam logic [5:0] LAST_BYTE  = 6'(DIGEST_BYTES - 1);

    state_t state;
    // need_pad: the last block was exactly RATE_BYTES long, so padding needs a block of its own.
    // final_blk: the padded block is in the state; the next permutation leads to squeeze.
    logic   need_pad;
    logic   final_blk;
    logic   wdog_expired;

`ifdef SHA3_SEQ_TIMEOUT_EN
    localparam logic [10:0] WDOG_LAST = 11'(TIMEOUT_CYCLES - 1);

    logic [10:0] wdog;

    // Counts cycles spent in ABS_WAIT; held at zero elsewhere so every entry starts fresh.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wdog <= '0;
        end else if (state == ABS_WAIT) begin
            wdog <= wdog + 11'd1;
        end else begin
            wdog <= '0;
        end
    end

    assign wdog_expired = (wdog == WDOG_LAST);
`else
    logic unused_timeout;

    assign wdog_expired   = 1'b0;
    // The limit only sizes the watchdog; keep it referenced when the watchdog is absent.
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            need_pad     <= 1'b0;
            final_blk    <= 1'b0;
            absorb_go    <= 1'b0;
            absorb_kill  <= 1'b0;
            state_clr    <= 1'b0;
            pad_strobe   <= 1'b0;
            pad_pos      <= '0;
            perm_en      <= 1'b0;
            round_idx    <= '0;
            dig_valid    <= 1'b0;
            dig_byte_sel <= '0;
            dig_last     <= 1'b0;
            busy         <= 1'b0;
            hash_done    <= 1'b0;
            error        <= 1'b0;
        end else begin
            // Single-cycle strobes default low; the transitions below raise them for one cycle.
            absorb_go   <= 1'b0;
            absorb_kill <= 1'b0;
            state_clr   <= 1'b0;
            pad_strobe  <= 1'b0;
            hash_done   <= 1'b0;

            if (state != IDLE && abort_req) begin
                // Abort outranks every other transition, including from ABORT itself (stay).
                state        <= ABORT;
                absorb_kill  <= 1'b1;
                perm_en      <= 1'b0;
                round_idx    <= '0;
                dig_valid    <= 1'b0;
                dig_byte_sel <= '0;
                dig_last     <= 1'b0;
                need_pad     <= 1'b0;
                final_blk    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state     <= CLEAR;
                            state_clr <= 1'b1;
                            error     <= 1'b0;
                            busy      <= 1'b1;
                            need_pad  <= 1'b0;
                            final_blk <= 1'b0;
                            pad_pos   <= '0;
                        end
                    end
                    CLEAR: begin
                        state     <= ABS_GO;
                        absorb_go <= 1'b1;
                    end
                    ABS_GO: begin
                        state <= ABS_WAIT;
                    end
                    ABS_WAIT: begin
                        // absorb_done takes precedence over a watchdog expiring in the same cycle.
                        if (absorb_done) begin
                            if (absorb_count > RATE_L) begin
                                state       <= ERROR;
                                absorb_kill <= 1'b1;
                                error       <= 1'b1;
                            end else if (absorb_count < RATE_L) begin
                                state      <= PAD;
                                pad_pos    <= absorb_count;
                                pad_strobe <= 1'b1;
                            end else begin
                                // Full block; if the message ends here, padding follows in a block of its own.
                                if (data_done && fifo_empty) begin
                                    need_pad <= 1'b1;
                                    pad_pos  <= '0;
                                end
                                state     <= PERM;
                                perm_en   <= 1'b1;
                                round_idx <= '0;
                            end
                        end else if (wdog_expired) begin
                            state       <= ERROR;
                            absorb_kill <= 1'b1;
                            error       <= 1'b1;
                        end
                    end
                    PAD: begin
                        state     <= PERM;
                        need_pad  <= 1'b0;
                        final_blk <= 1'b1;
                        perm_en   <= 1'b1;
                        round_idx <= '0;
                    end
                    PERM: begin
                        if (round_idx == LAST_ROUND) begin
                            perm_en   <= 1'b0;
                            round_idx <= '0;
                            if (final_blk) begin
                                state        <= SQUEEZE;
                                dig_valid    <= 1'b1;
                                dig_byte_sel <= '0;
                                dig_last     <= (LAST_BYTE == 6'd0);
                            end else if (need_pad) begin
                                state      <= PAD;
                                pad_strobe <= 1'b1;
                            end else begin
                                state     <= ABS_GO;
                                absorb_go <= 1'b1;
                            end
                        end else begin
                            round_idx <= round_idx + 5'd1;
                        end
                    end
                    SQUEEZE: begin
                        // dig_valid is high throughout SQUEEZE, so dig_ready alone completes a handshake.
                        if (dig_ready) begin
                            if (dig_byte_sel == LAST_BYTE) begin
                                state        <= DONE;
                                dig_valid    <= 1'b0;
                                dig_last     <= 1'b0;
                                dig_byte_sel <= '0;
                                hash_done    <= 1'b1;
                            end else begin
                                dig_byte_sel <= dig_byte_sel + 6'd1;
                                dig_last     <= ((dig_byte_sel + 6'd1) == LAST_BYTE);
                            end
                        end
                    end
                    DONE: begin
                        state     <= IDLE;
                        final_blk <= 1'b0;
                        need_pad  <= 1'b0;
                        busy      <= 1'b0;
                    end
                    ABORT: begin
                        // Reached only with abort_req low; the abort branch above holds ABORT otherwise.
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    ERROR: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sha3_sequencer.sv
// tb_sha3_sequencer: directed scenarios for the SHA3-512 sequencer with an event scoreboard.
// Latency: expected control events carry the cycle gap from the previous event (0 = any gap).
// Backpressure: dig_ready is either held high or follows a 1,0,0,1 pattern.
`timescale 1ns/1ps
module tb_sha3_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort_req;
    logic       data_done;
    logic       fifo_empty;
    logic       absorb_go;
    logic       absorb_kill;
    logic       absorb_done;
    logic [6:0] absorb_count;
    logic       state_clr;
    logic       pad_strobe;
    logic [6:0] pad_pos;
    logic       perm_en;
    logic [4:0] round_idx;
    logic       dig_valid;
    logic       dig_ready;
    logic [5:0] dig_byte_sel;
    logic       dig_last;
    logic       busy;
    logic       hash_done;
    logic       error;

    always #5 clk = ~clk;

    sha3_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort_req    (abort_req),
        .data_done    (data_done),
        .fifo_empty   (fifo_empty),
        .absorb_go    (absorb_go),
        .absorb_kill  (absorb_kill),
        .absorb_done  (absorb_done),
        .absorb_count (absorb_count),
        .state_clr    (state_clr),
        .pad_strobe   (pad_strobe),
        .pad_pos      (pad_pos),
        .perm_en      (perm_en),
        .round_idx    (round_idx),
        .dig_valid    (dig_valid),
        .dig_ready    (dig_ready),
        .dig_byte_sel (dig_byte_sel),
        .dig_last     (dig_last),
        .busy         (busy),
        .hash_done    (hash_done),
        .error        (error)
    );

    logic [27:0] outs;
    assign outs = {absorb_go, absorb_kill, state_clr, pad_strobe, pad_pos, perm_en, round_idx,
                   dig_valid, dig_byte_sel, dig_last, busy, hash_done, error};

    typedef enum logic [2:0] {EV_CLR, EV_GO, EV_PAD, EV_PERM, EV_DIG, EV_DONE, EV_KILL} ev_kind_t;
    typedef struct packed {
        ev_kind_t    kind;
        logic [7:0]  val;
        logic [15:0] gap;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    int  last_cyc = 0;
    bit  bp_mode  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic void push(input ev_kind_t k, input int v, input int g);
        ev_t e;
        e.kind = k;
        e.val  = 8'(v);
        e.gap  = 16'(g);
        exp_q.push_back(e);
    endfunction

    function automatic void push_perm(input int first_gap, input int last_round);
        for (int r = 0; r <= last_round; r++) push(EV_PERM, r, (r == 0) ? first_gap : 1);
    endfunction

    // Digest value packs {dig_last, dig_byte_sel}: only byte 63 carries last (64 + 63 = 127).
    function automatic void push_digest(input bit ready_always);
        for (int i = 0; i < 64; i++) push(EV_DIG, (i == 63) ? 127 : i, ready_always ? 1 : 0);
        push(EV_DONE, 0, 1);
    endfunction

    function automatic void push_empty_msg(input bit ready_always);
        push(EV_CLR, 0, 1);
        push(EV_GO, 0, 1);
        push(EV_PAD, 0, 2);
        push_perm(1, 23);
        push_digest(ready_always);
    endfunction

    task automatic observe(input ev_kind_t k, input logic [7:0] v);
        ev_t e;
        int  g;
        g        = cyc - last_cyc;
        last_cyc = cyc;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_%s: got val=%0d at cycle %0d, required no event", k.name(), v, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v || (e.gap != 0 && int'(e.gap) != g)) begin
                n_fail++;
                $display("FAIL ev_%s: got %s val=%0d gap=%0d, required %s val=%0d gap=%0d",
                         e.kind.name(), k.name(), v, g, e.kind.name(), e.val, e.gap);
            end
        end
    endtask

    // Monitor: samples on the falling edge, turns each asserted control output into an event.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (reset && start && !busy) last_cyc = cyc;
            if (state_clr)              observe(EV_CLR, 8'd0);
            if (absorb_go)              observe(EV_GO, 8'd0);
            if (pad_strobe)             observe(EV_PAD, {1'b0, pad_pos});
            if (perm_en)                observe(EV_PERM, {3'b0, round_idx});
            if (dig_valid && dig_ready) observe(EV_DIG, {1'b0, dig_last, dig_byte_sel});
            if (hash_done)              observe(EV_DONE, 8'd0);
            if (absorb_kill)            observe(EV_KILL, {7'b0, error});
        end
    end

    // Consumer: always ready, or the repeating 1,0,0,1 pattern in backpressure mode.
    initial begin
        int bp_cnt;
        bp_cnt    = 0;
        dig_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                dig_ready = (bp_cnt % 4 == 0) || (bp_cnt % 4 == 3);
                bp_cnt++;
            end else begin
                dig_ready = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input bit with_abort);
        tick();
        start     = 1'b1;
        abort_req = with_abort;
        tick();
        start     = 1'b0;
        abort_req = 1'b0;
    endtask

    task automatic absorb(input int n, input bit dd, input bit fe);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (absorb_go) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_absorb_go: got no absorb_go in 200 cycles, required one");
        end else begin
            tick();
            absorb_done  = 1'b1;
            absorb_count = 7'(n);
            data_done    = dd;
            fifo_empty   = fe;
            tick();
            absorb_done  = 1'b0;
            absorb_count = '0;
            data_done    = 1'b0;
            fifo_empty   = 1'b0;
        end
    endtask

    task automatic wait_round(input int r);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (perm_en && round_idx == 5'(r)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_round: got no round_idx=%0d in 300 cycles, required one", r);
        end
    endtask

    task automatic drain(input int bound, input string name);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) @(negedge clk);
        check(name, exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset        = 1'b0;
        start        = 1'b0;
        abort_req    = 1'b0;
        data_done    = 1'b0;
        fifo_empty   = 1'b0;
        absorb_done  = 1'b0;
        absorb_count = '0;

        repeat (3) @(negedge clk);
        check("reset_outputs", 32'(outs), 0);
        tick();
        reset = 1'b1;

        // Empty message: pad at byte 0, one permutation, 64-byte digest.
        push_empty_msg(1'b1);
        do_start(1'b0);
        absorb(0, 1'b1, 1'b1);
        drain(200, "empty_drain");
        check("empty_busy", busy, 0);
        check("empty_error", error, 0);

        // Exactly one full block at end of message: padding needs its own permutation.
        push(EV_CLR, 0, 1);
        push(EV_GO, 0, 1);
        push_perm(2, 23);
        push(EV_PAD, 0, 1);
        push_perm(1, 23);
        push_digest(1'b1);
        do_start(1'b0);
        absorb(72, 1'b1, 1'b1);
        drain(200, "full72_drain");
        check("full72_busy", busy, 0);

        // 100 bytes: full block (FIFO not yet empty) then 28-byte tail.
        push(EV_CLR, 0, 1);
        push(EV_GO, 0, 1);
        push_perm(2, 23);
        push(EV_GO, 0, 1);
        push(EV_PAD, 28, 2);
        push_perm(1, 23);
        push_digest(1'b1);
        do_start(1'b0);
        absorb(72, 1'b1, 1'b0);
        absorb(28, 1'b1, 1'b1);
        drain(200, "msg100_drain");
        check("msg100_busy", busy, 0);

        // Digest backpressure, plus a start pulse while busy that must be ignored.
        bp_mode = 1'b1;
        push_empty_msg(1'b0);
        do_start(1'b0);
        absorb(0, 1'b1, 1'b1);
        wait_round(23);
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        drain(400, "bp_drain");
        bp_mode = 1'b0;
        check("bp_busy", busy, 0);

        // Abort at round 10, held for three cycles.
        push(EV_CLR, 0, 1);
        push(EV_GO, 0, 1);
        push(EV_PAD, 0, 2);
        push_perm(1, 10);
        push(EV_KILL, 0, 1);
        push(EV_KILL, 0, 1);
        push(EV_KILL, 0, 1);
        do_start(1'b0);
        absorb(0, 1'b1, 1'b1);
        wait_round(10);
        abort_req = 1'b1;
        repeat (3) @(negedge clk);
        abort_req = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_kill_released", absorb_kill, 0);
        drain(20, "abort_drain");

        // abort_req in IDLE is ignored.
        abort_req = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_abort_busy", busy, 0);
        abort_req = 1'b0;

        // start with abort_req together in IDLE: start wins, hash runs normally.
        push_empty_msg(1'b1);
        do_start(1'b1);
        absorb(0, 1'b1, 1'b1);
        drain(200, "start_abort_drain");
        check("start_abort_busy", busy, 0);

        // Overlong block count: error response, sticky until next start.
        push(EV_CLR, 0, 1);
        push(EV_GO, 0, 1);
        push(EV_KILL, 1, 2);
        do_start(1'b0);
        absorb(80, 1'b0, 1'b0);
        drain(20, "err_drain");
        check("err_flag", error, 1);
        check("err_busy", busy, 0);
        repeat (5) @(negedge clk);
        check("err_sticky", error, 1);
        push_empty_msg(1'b1);
        do_start(1'b0);
        @(negedge clk);
        check("err_cleared_on_start", error, 0);
        absorb(0, 1'b1, 1'b1);
        drain(200, "after_err_drain");

        // Absorb block never answers.
        push(EV_CLR, 0, 1);
        push(EV_GO, 0, 1);
`ifdef SHA3_SEQ_TIMEOUT_EN
        push(EV_KILL, 1, 1025);
        do_start(1'b0);
        drain(1300, "wdog_drain");
        check("wdog_error", error, 1);
        check("wdog_busy", busy, 0);
`else
        do_start(1'b0);
        repeat (1100) @(negedge clk);
        check("wait_busy", busy, 1);
        check("wait_error", error, 0);
        push(EV_KILL, 0, 0);
        abort_req = 1'b1;
        tick();
        abort_req = 1'b0;
        drain(20, "wait_abort_drain");
        check("wait_abort_busy", busy, 0);
`endif

        // Reset in the middle of the second permutation of a 100-byte message.
        push(EV_CLR, 0, 1);
        push(EV_GO, 0, 1);
        push_perm(2, 23);
        push(EV_GO, 0, 1);
        push(EV_PAD, 28, 2);
        push_perm(1, 5);
        do_start(1'b0);
        absorb(72, 1'b0, 1'b0);
        absorb(28, 1'b1, 1'b1);
        wait_round(5);
        reset = 1'b0;
        @(negedge clk);
        check("midreset_outputs", 32'(outs), 0);
        tick();
        reset = 1'b1;
        drain(10, "midreset_drain");

        // Recovery after mid-operation reset.
        push_empty_msg(1'b1);
        do_start(1'b0);
        absorb(0, 1'b1, 1'b1);
        drain(200, "recover_drain");
        check("recover_busy", busy, 0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
